// File: rtl/execute_pkg.sv
// Shared constants and types for the execute stage: opcodes, group ext codes,
// RFLAGS bit positions and reset value, and the internal ALU operation enum.
package execute_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RIP_W = 32;
  localparam int unsigned REG_W = 4;
  localparam int unsigned EXT_W = 3;
  localparam int unsigned OPC_W = 8;

  localparam logic [OPC_W-1:0] OP_ADD       = 8'h01;
  localparam logic [OPC_W-1:0] OP_OR        = 8'h09;
  localparam logic [OPC_W-1:0] OP_AND       = 8'h21;
  localparam logic [OPC_W-1:0] OP_SUB       = 8'h29;
  localparam logic [OPC_W-1:0] OP_XOR       = 8'h31;
  localparam logic [OPC_W-1:0] OP_CMP       = 8'h39;
  localparam logic [OPC_W-1:0] OP_MOV       = 8'h89;
  localparam logic [OPC_W-1:0] OP_MOVI_BASE = 8'hB8;
  localparam logic [OPC_W-1:0] OP_GRP81     = 8'h81;
  localparam logic [OPC_W-1:0] OP_GRP83     = 8'h83;
  localparam logic [OPC_W-1:0] OP_GRPFF     = 8'hFF;
  localparam logic [OPC_W-1:0] OP_GRPF7     = 8'hF7;

  // ModRM.reg selector for the 0x81/0x83 immediate groups
  typedef enum logic [EXT_W-1:0] {
    EXT_ADD = 3'd0,
    EXT_OR  = 3'd1,
    EXT_AND = 3'd4,
    EXT_SUB = 3'd5,
    EXT_XOR = 3'd6,
    EXT_CMP = 3'd7
  } grpExt_e;

  localparam logic [EXT_W-1:0] EXT_INC = 3'd0;
  localparam logic [EXT_W-1:0] EXT_DEC = 3'd1;
  localparam logic [EXT_W-1:0] EXT_MUL = 3'd4;

  localparam int unsigned CF_BIT = 0;
  localparam int unsigned ZF_BIT = 6;
  localparam int unsigned SF_BIT = 7;
  localparam int unsigned OF_BIT = 11;

  localparam logic [XLEN-1:0] RFLAGS_RESET = 64'h0000_0000_0020_0200;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_OR,
    ALU_AND,
    ALU_SUB,
    ALU_XOR,
    ALU_CMP,
    ALU_MOV,
    ALU_MOVI,
    ALU_INC,
    ALU_DEC,
    ALU_MUL
  } aluOp_e;

  // Map an immediate-group ext code to its ALU operation (ALU_NONE if unsupported)
  function automatic aluOp_e groupOp(input logic [EXT_W-1:0] ext);
    aluOp_e op;
    op = ALU_NONE;
    case (ext)
      EXT_ADD: op = ALU_ADD;
      EXT_OR:  op = ALU_OR;
      EXT_AND: op = ALU_AND;
      EXT_SUB: op = ALU_SUB;
      EXT_XOR: op = ALU_XOR;
      EXT_CMP: op = ALU_CMP;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational decode, result and RFLAGS computation for the execute stage.
// Optional feature macro: EXECUTE_STAGE_MUL_EN enables 0xF7 /4 unsigned MUL.
module execute_alu
  import execute_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [EXT_W-1:0] extOpcode,
  input  logic [XLEN-1:0]  val1,
  input  logic [XLEN-1:0]  val2,
  input  logic [XLEN-1:0]  imm64,
  input  logic [XLEN-1:0]  flagsIn,
  output logic             supported_c,
  output logic             writesReg_c,
  output logic             writesSpecial_c,
  output logic [XLEN-1:0]  result_c,
  output logic [XLEN-1:0]  resultHi_c,
  output logic [XLEN-1:0]  flags_c
);

  aluOp_e          op;
  logic [XLEN-1:0] opB;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic            addOf;
  logic            subOf;
  logic            cf;
  logic            of;
  logic            writesFlags;
  logic            keepCf;
`ifdef EXECUTE_STAGE_MUL_EN
  logic [2*XLEN-1:0] prod;
`endif

  // Decode opcode/ext into an operation and select the second operand
  always_comb begin
    op  = ALU_NONE;
    opB = val2;
    case (opcode)
      OP_ADD: op = ALU_ADD;
      OP_OR:  op = ALU_OR;
      OP_AND: op = ALU_AND;
      OP_SUB: op = ALU_SUB;
      OP_XOR: op = ALU_XOR;
      OP_CMP: op = ALU_CMP;
      OP_MOV: op = ALU_MOV;
      OP_GRP81: begin
        op  = groupOp(extOpcode);
        opB = {{32{imm64[31]}}, imm64[31:0]};
      end
      OP_GRP83: begin
        op  = groupOp(extOpcode);
        opB = {{56{imm64[7]}}, imm64[7:0]};
      end
      OP_GRPFF: begin
        opB = XLEN'(1);
        if (extOpcode == EXT_INC)      op = ALU_INC;
        else if (extOpcode == EXT_DEC) op = ALU_DEC;
      end
`ifdef EXECUTE_STAGE_MUL_EN
      OP_GRPF7: begin
        if (extOpcode == EXT_MUL) op = ALU_MUL;
      end
`endif
      default: begin
        if (opcode[7:3] == OP_MOVI_BASE[7:3]) begin
          op  = ALU_MOVI;
          opB = imm64;
        end
      end
    endcase
  end

  assign sum   = {1'b0, val1} + {1'b0, opB};
  assign diff  = {1'b0, val1} - {1'b0, opB};
  assign addOf = (val1[XLEN-1] == opB[XLEN-1]) && (sum[XLEN-1] != val1[XLEN-1]);
  assign subOf = (val1[XLEN-1] != opB[XLEN-1]) && (diff[XLEN-1] != val1[XLEN-1]);
`ifdef EXECUTE_STAGE_MUL_EN
  assign prod  = (2*XLEN)'(val1) * (2*XLEN)'(val2);
`endif

  // Compute result, write enables and the updated RFLAGS
  always_comb begin
    supported_c     = 1'b1;
    writesReg_c     = 1'b1;
    writesSpecial_c = 1'b0;
    writesFlags     = 1'b1;
    keepCf          = 1'b0;
    result_c        = val1;
    resultHi_c      = '0;
    cf              = 1'b0;
    of              = 1'b0;
    case (op)
      ALU_ADD, ALU_INC: begin
        result_c = sum[XLEN-1:0];
        cf       = sum[XLEN];
        of       = addOf;
        keepCf   = (op == ALU_INC);
      end
      ALU_SUB, ALU_DEC, ALU_CMP: begin
        result_c    = diff[XLEN-1:0];
        cf          = diff[XLEN];
        of          = subOf;
        keepCf      = (op == ALU_DEC);
        writesReg_c = (op != ALU_CMP);
      end
      ALU_OR:  result_c = val1 | opB;
      ALU_AND: result_c = val1 & opB;
      ALU_XOR: result_c = val1 ^ opB;
      ALU_MOV, ALU_MOVI: begin
        result_c    = opB;
        writesFlags = 1'b0;
      end
`ifdef EXECUTE_STAGE_MUL_EN
      ALU_MUL: begin
        result_c        = prod[XLEN-1:0];
        resultHi_c      = prod[2*XLEN-1:XLEN];
        cf              = |prod[2*XLEN-1:XLEN];
        of              = |prod[2*XLEN-1:XLEN];
        writesSpecial_c = 1'b1;
      end
`endif
      default: begin
        supported_c = 1'b0;
        writesReg_c = 1'b0;
        writesFlags = 1'b0;
      end
    endcase

    flags_c = flagsIn;
    if (writesFlags) begin
      if (!keepCf) flags_c[CF_BIT] = cf;
      flags_c[ZF_BIT] = (result_c == '0);
      flags_c[SF_BIT] = result_c[XLEN-1];
      flags_c[OF_BIT] = of;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Single-cycle integer execute stage: accept logic and output registers
// around execute_alu. Optional feature macro: EXECUTE_STAGE_MUL_EN (0xF7 /4 MUL).
module execute_stage
  import execute_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              can_execute,
  input  logic [RIP_W-1:0]  current_rip,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              opcode_valid,
  input  logic              has_ext_opcode,
  input  logic [EXT_W-1:0]  ext_opcode,
  input  logic [XLEN-1:0]   operand_val1,
  input  logic [XLEN-1:0]   operand_val2,
  input  logic              operand_val1_valid,
  input  logic              operand_val2_valid,
  input  logic [3:0]        imm_len,
  input  logic [XLEN-1:0]   imm64,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic [REG_W-1:0]  dest_reg_special,
  input  logic              dest_reg_special_valid,
  output logic [XLEN-1:0]   alu_result,
  output logic [XLEN-1:0]   alu_result_special,
  output logic [REG_W-1:0]  dest_reg_out,
  output logic [REG_W-1:0]  dest_reg_special_out,
  output logic              write_en_out,
  output logic              write_special_en_out,
  output logic              valid_out,
  output logic [RIP_W-1:0]  rip_out,
  output logic [XLEN-1:0]   rflags_out
);

  logic            supported_c;
  logic            writesReg_c;
  logic            writesSpecial_c;
  logic [XLEN-1:0] result_c;
  logic [XLEN-1:0] resultHi_c;
  logic [XLEN-1:0] flags_c;
  logic            accept;

  // Immediate width is implied by the opcode and operands are assumed ready
  logic unusedInputs;
  assign unusedInputs = ^{has_ext_opcode, imm_len, operand_val1_valid, operand_val2_valid};

  execute_alu u_alu (
    .opcode          (opcode),
    .extOpcode       (ext_opcode),
    .val1            (operand_val1),
    .val2            (operand_val2),
    .imm64           (imm64),
    .flagsIn         (rflags_out),
    .supported_c     (supported_c),
    .writesReg_c     (writesReg_c),
    .writesSpecial_c (writesSpecial_c),
    .result_c        (result_c),
    .resultHi_c      (resultHi_c),
    .flags_c         (flags_c)
  );

  assign accept = can_execute && opcode_valid && supported_c;

  // Output registers: strobes follow every cycle, data and flags load only on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result           <= '0;
      alu_result_special   <= '0;
      dest_reg_out         <= '0;
      dest_reg_special_out <= '0;
      write_en_out         <= 1'b0;
      write_special_en_out <= 1'b0;
      valid_out            <= 1'b0;
      rip_out              <= '0;
      rflags_out           <= RFLAGS_RESET;
    end else begin
      valid_out            <= accept;
      write_en_out         <= accept && writesReg_c;
      write_special_en_out <= accept && writesSpecial_c && dest_reg_special_valid;
      if (accept) begin
        alu_result           <= result_c;
        alu_result_special   <= resultHi_c;
        dest_reg_out         <= dest_reg;
        dest_reg_special_out <= dest_reg_special;
        rip_out              <= current_rip;
        rflags_out           <= flags_c;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        can_execute;
  logic [31:0] current_rip;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic        has_ext_opcode;
  logic [2:0]  ext_opcode;
  logic [63:0] operand_val1;
  logic [63:0] operand_val2;
  logic        operand_val1_valid;
  logic        operand_val2_valid;
  logic [3:0]  imm_len;
  logic [63:0] imm64;
  logic [3:0]  dest_reg;
  logic [3:0]  dest_reg_special;
  logic        dest_reg_special_valid;
  logic [63:0] alu_result;
  logic [63:0] alu_result_special;
  logic [3:0]  dest_reg_out;
  logic [3:0]  dest_reg_special_out;
  logic        write_en_out;
  logic        write_special_en_out;
  logic        valid_out;
  logic [31:0] rip_out;
  logic [63:0] rflags_out;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .can_execute            (can_execute),
    .current_rip            (current_rip),
    .opcode                 (opcode),
    .opcode_valid           (opcode_valid),
    .has_ext_opcode         (has_ext_opcode),
    .ext_opcode             (ext_opcode),
    .operand_val1           (operand_val1),
    .operand_val2           (operand_val2),
    .operand_val1_valid     (operand_val1_valid),
    .operand_val2_valid     (operand_val2_valid),
    .imm_len                (imm_len),
    .imm64                  (imm64),
    .dest_reg               (dest_reg),
    .dest_reg_special       (dest_reg_special),
    .dest_reg_special_valid (dest_reg_special_valid),
    .alu_result             (alu_result),
    .alu_result_special     (alu_result_special),
    .dest_reg_out           (dest_reg_out),
    .dest_reg_special_out   (dest_reg_special_out),
    .write_en_out           (write_en_out),
    .write_special_en_out   (write_special_en_out),
    .valid_out              (valid_out),
    .rip_out                (rip_out),
    .rflags_out             (rflags_out)
  );

  always #5 clk = ~clk;

  // Present one instruction at the falling edge, return just after the next rising edge
  task automatic issue(input logic ce, input logic ov, input logic [7:0] op, input logic [2:0] ext,
                       input logic [63:0] v1, input logic [63:0] v2, input logic [63:0] imm,
                       input logic [3:0] dr, input logic [31:0] rip);
    @(negedge clk);
    can_execute            = ce;
    opcode_valid           = ov;
    opcode                 = op;
    ext_opcode             = ext;
    has_ext_opcode         = 1'b1;
    operand_val1           = v1;
    operand_val2           = v2;
    operand_val1_valid     = 1'b1;
    operand_val2_valid     = 1'b1;
    imm64                  = imm;
    imm_len                = 4'd8;
    dest_reg               = dr;
    dest_reg_special       = 4'd5;
    dest_reg_special_valid = 1'b1;
    current_rip            = rip;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    can_execute = 1'b0; opcode_valid = 1'b0; opcode = 8'h00; ext_opcode = 3'd0;
    has_ext_opcode = 1'b0; operand_val1 = '0; operand_val2 = '0;
    operand_val1_valid = 1'b0; operand_val2_valid = 1'b0; imm_len = 4'd0; imm64 = '0;
    dest_reg = '0; dest_reg_special = '0; dest_reg_special_valid = 1'b0; current_rip = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (write_en_out !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", write_en_out); end
    checks++; if (write_special_en_out !== 1'b0) begin errors++; $display("FAIL reset_wse got=%b exp=0", write_special_en_out); end
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", alu_result); end
    checks++; if (rflags_out !== 64'h200200) begin errors++; $display("FAIL reset_rflags got=%h exp=200200", rflags_out); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add_carry();
    issue(1'b1, 1'b1, 8'h01, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'd2, 32'h0000_4000);
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL add_result got=%h exp=0", alu_result); end
    checks++; if (rflags_out !== 64'h200241) begin errors++; $display("FAIL add_flags got=%h exp=200241", rflags_out); end
    checks++; if (write_en_out !== 1'b1) begin errors++; $display("FAIL add_we got=%b exp=1", write_en_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", valid_out); end
    checks++; if (dest_reg_out !== 4'd2) begin errors++; $display("FAIL add_dest got=%h exp=2", dest_reg_out); end
    checks++; if (rip_out !== 32'h0000_4000) begin errors++; $display("FAIL add_rip got=%h exp=4000", rip_out); end
    checks++; if (write_special_en_out !== 1'b0) begin errors++; $display("FAIL add_wse got=%b exp=0", write_special_en_out); end
  endtask

  task automatic test_group_imm();
    issue(1'b1, 1'b1, 8'h83, 3'd5, 64'h0, 64'h1234, 64'h80, 4'd1, 32'h10);
    checks++; if (alu_result !== 64'h80) begin errors++; $display("FAIL g83sub_result got=%h exp=80", alu_result); end
    checks++; if (rflags_out !== 64'h200201) begin errors++; $display("FAIL g83sub_flags got=%h exp=200201", rflags_out); end
    issue(1'b1, 1'b1, 8'h81, 3'd0, 64'h5, 64'h1234, 64'hFFFF_FFFF, 4'd1, 32'h14);
    checks++; if (alu_result !== 64'h4) begin errors++; $display("FAIL g81add_result got=%h exp=4", alu_result); end
    checks++; if (rflags_out !== 64'h200201) begin errors++; $display("FAIL g81add_flags got=%h exp=200201", rflags_out); end
  endtask

  task automatic test_cmp();
    issue(1'b1, 1'b1, 8'h39, 3'd0, 64'h5, 64'h5, 64'h0, 4'd4, 32'h20);
    checks++; if (rflags_out !== 64'h200240) begin errors++; $display("FAIL cmp_flags got=%h exp=200240", rflags_out); end
    checks++; if (write_en_out !== 1'b0) begin errors++; $display("FAIL cmp_we got=%b exp=0", write_en_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL cmp_valid got=%b exp=1", valid_out); end
  endtask

  task automatic test_mov();
    issue(1'b1, 1'b1, 8'hBB, 3'd0, 64'h0, 64'h0, 64'h1122_3344_5566_7788, 4'd3, 32'h24);
    checks++; if (alu_result !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL movi_result got=%h exp=1122334455667788", alu_result); end
    checks++; if (dest_reg_out !== 4'd3) begin errors++; $display("FAIL movi_dest got=%h exp=3", dest_reg_out); end
    checks++; if (rflags_out !== 64'h200240) begin errors++; $display("FAIL movi_flags got=%h exp=200240", rflags_out); end
    checks++; if (write_en_out !== 1'b1) begin errors++; $display("FAIL movi_we got=%b exp=1", write_en_out); end
    issue(1'b1, 1'b1, 8'h89, 3'd0, 64'h1, 64'hDEAD_BEEF, 64'h0, 4'd6, 32'h28);
    checks++; if (alu_result !== 64'hDEAD_BEEF) begin errors++; $display("FAIL mov_result got=%h exp=deadbeef", alu_result); end
    checks++; if (rflags_out !== 64'h200240) begin errors++; $display("FAIL mov_flags got=%h exp=200240", rflags_out); end
  endtask

  task automatic test_sub_logic();
    issue(1'b1, 1'b1, 8'h29, 3'd0, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 4'd7, 32'h30);
    checks++; if (alu_result !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_result got=%h exp=7fffffffffffffff", alu_result); end
    checks++; if (rflags_out !== 64'h200A00) begin errors++; $display("FAIL sub_flags got=%h exp=200a00", rflags_out); end
    issue(1'b1, 1'b1, 8'h09, 3'd0, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 4'd7, 32'h34);
    checks++; if (alu_result !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL or_result got=%h exp=8000000000000001", alu_result); end
    checks++; if (rflags_out !== 64'h200280) begin errors++; $display("FAIL or_flags got=%h exp=200280", rflags_out); end
    issue(1'b1, 1'b1, 8'h21, 3'd0, 64'hF0F0, 64'h0F0F, 64'h0, 4'd7, 32'h38);
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL and_result got=%h exp=0", alu_result); end
    checks++; if (rflags_out !== 64'h200240) begin errors++; $display("FAIL and_flags got=%h exp=200240", rflags_out); end
    issue(1'b1, 1'b1, 8'h31, 3'd0, 64'hFF00, 64'h0FF0, 64'h0, 4'd7, 32'h3C);
    checks++; if (alu_result !== 64'hF0F0) begin errors++; $display("FAIL xor_result got=%h exp=f0f0", alu_result); end
  endtask

  task automatic test_inc_dec();
    issue(1'b1, 1'b1, 8'h01, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'd1, 32'h40);
    issue(1'b1, 1'b1, 8'hFF, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 4'd1, 32'h44);
    checks++; if (alu_result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL inc_result got=%h exp=8000000000000000", alu_result); end
    checks++; if (rflags_out !== 64'h200A81) begin errors++; $display("FAIL inc_flags got=%h exp=200a81", rflags_out); end
    issue(1'b1, 1'b1, 8'hFF, 3'd1, 64'h1, 64'h0, 64'h0, 4'd1, 32'h48);
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL dec_result got=%h exp=0", alu_result); end
    checks++; if (rflags_out !== 64'h200241) begin errors++; $display("FAIL dec_flags got=%h exp=200241", rflags_out); end
  endtask

  task automatic test_bubble();
    issue(1'b0, 1'b1, 8'h01, 3'd0, 64'h7, 64'h9, 64'h0, 4'd9, 32'h50);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", valid_out); end
    checks++; if (write_en_out !== 1'b0) begin errors++; $display("FAIL idle_we got=%b exp=0", write_en_out); end
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL idle_hold got=%h exp=0", alu_result); end
    checks++; if (rflags_out !== 64'h200241) begin errors++; $display("FAIL idle_flags got=%h exp=200241", rflags_out); end
    issue(1'b1, 1'b1, 8'h90, 3'd0, 64'h7, 64'h9, 64'h0, 4'd9, 32'h54);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL unsup_valid got=%b exp=0", valid_out); end
    issue(1'b1, 1'b1, 8'h83, 3'd2, 64'h7, 64'h9, 64'h1, 4'd9, 32'h58);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL g83ext2_valid got=%b exp=0", valid_out); end
    issue(1'b1, 1'b0, 8'h01, 3'd0, 64'h7, 64'h9, 64'h0, 4'd9, 32'h5C);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL opinvalid_valid got=%b exp=0", valid_out); end
    checks++; if (dest_reg_out !== 4'd1) begin errors++; $display("FAIL bubble_dest_hold got=%h exp=1", dest_reg_out); end
    checks++; if (rflags_out !== 64'h200241) begin errors++; $display("FAIL bubble_flags got=%h exp=200241", rflags_out); end
  endtask

  task automatic test_mul();
    issue(1'b1, 1'b1, 8'hF7, 3'd4, 64'h8000_0000_0000_0000, 64'h4, 64'h0, 4'd2, 32'h60);
`ifdef EXECUTE_STAGE_MUL_EN
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL mul_lo got=%h exp=0", alu_result); end
    checks++; if (alu_result_special !== 64'h2) begin errors++; $display("FAIL mul_hi got=%h exp=2", alu_result_special); end
    checks++; if (rflags_out !== 64'h200A41) begin errors++; $display("FAIL mul_flags got=%h exp=200a41", rflags_out); end
    checks++; if (write_special_en_out !== 1'b1) begin errors++; $display("FAIL mul_wse got=%b exp=1", write_special_en_out); end
    checks++; if (dest_reg_special_out !== 4'd5) begin errors++; $display("FAIL mul_dest_sp got=%h exp=5", dest_reg_special_out); end
`else
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL f7_valid got=%b exp=0", valid_out); end
    checks++; if (write_special_en_out !== 1'b0) begin errors++; $display("FAIL f7_wse got=%b exp=0", write_special_en_out); end
    checks++; if (rflags_out !== 64'h200241) begin errors++; $display("FAIL f7_flags got=%h exp=200241", rflags_out); end
`endif
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b1, 8'h01, 3'd0, 64'h1, 64'h2, 64'h0, 4'd8, 32'h70);
    checks++; if (alu_result !== 64'h3) begin errors++; $display("FAIL b2b_add got=%h exp=3", alu_result); end
    checks++; if (rflags_out !== 64'h200200) begin errors++; $display("FAIL b2b_add_flags got=%h exp=200200", rflags_out); end
    issue(1'b1, 1'b1, 8'h29, 3'd0, 64'h3, 64'h3, 64'h0, 4'd9, 32'h74);
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL b2b_sub got=%h exp=0", alu_result); end
    checks++; if (dest_reg_out !== 4'd9) begin errors++; $display("FAIL b2b_dest got=%h exp=9", dest_reg_out); end
    checks++; if (rflags_out !== 64'h200240) begin errors++; $display("FAIL b2b_sub_flags got=%h exp=200240", rflags_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", valid_out); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", valid_out); end
    checks++; if (rflags_out !== 64'h200200) begin errors++; $display("FAIL rstmid_flags got=%h exp=200200", rflags_out); end
    checks++; if (write_en_out !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b exp=0", write_en_out); end
    checks++; if (alu_result !== 64'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", alu_result); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    opcode = 8'h01; operand_val1 = 64'h10; operand_val2 = 64'h20;
    can_execute = 1'b1; opcode_valid = 1'b1; dest_reg = 4'd4; current_rip = 32'h80;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstrel_early got=%b exp=0", valid_out); end
    @(posedge clk);
    #1;
    checks++; if (alu_result !== 64'h30) begin errors++; $display("FAIL rstrel_result got=%h exp=30", alu_result); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rstrel_valid got=%b exp=1", valid_out); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_group_imm();
    test_cmp();
    test_mov();
    test_sub_logic();
    test_inc_dec();
    test_bubble();
    test_mul();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
